// File: rtl/fb_pkg.sv
// Shared constants and state encoding for the framebuffer pixel writer.
package fb_pkg;
  localparam int CORDW     = 10;
  localparam int COLRW     = 4;
  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 180;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int FB_ADDRW  = $clog2(FB_PIXELS);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} fb_wr_state_t;
endpackage

// File: rtl/fb_addr_calc.sv
// Registered linear address: y*FB_WIDTH + x, or a direct linear address
// when sel_lin is set. Holds its value while en is low.
module fb_addr_calc
  import fb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sel_lin,
  input  logic [FB_ADDRW-1:0] lin,
  input  logic [CORDW-1:0]    x,
  input  logic [CORDW-1:0]    y,
  output logic [FB_ADDRW-1:0] addr
);
  // Wide enough for any y*FB_WIDTH + x before truncation.
  localparam int PW = CORDW + $clog2(FB_WIDTH) + 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (en) begin
      if (sel_lin)
        addr <= lin;
      else
        addr <= FB_ADDRW'(PW'(y) * PW'(FB_WIDTH) + PW'(x));
    end
  end
endmodule

// File: rtl/fb_pixel_writer.sv
// Clips drawer pixels to the framebuffer, converts them to linear addresses
// and writes them out one per cycle; also sweeps a full-screen clear.
//
// state | meaning
// IDLE  | accepting pixels from the drawer
// DRAIN | clear requested, waiting for in-flight pixels to be written
// CLEAR | writing clear colour to every address
module fb_pixel_writer
  import fb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                pix_valid,
  input  logic [CORDW-1:0]    x,
  input  logic [CORDW-1:0]    y,
  input  logic [COLRW-1:0]    colr,
  output logic                oe,
  input  logic                clear_start,
  input  logic [COLRW-1:0]    clear_colr,
  input  logic                fb_ready,
  output logic                fb_we,
  output logic [FB_ADDRW-1:0] fb_addr,
  output logic [COLRW-1:0]    fb_colr,
  output logic                busy,
  output logic                clear_done,
  output logic [15:0]         clip_cnt
);
  localparam int CNTW = FB_ADDRW + 1;
  localparam logic [CNTW-1:0] CNT_END = CNTW'(FB_PIXELS);

  fb_wr_state_t state, state_n;

  logic             stall, adv, accept, in_bounds, drained, clear_fin, addr_en;
  logic             s1_valid;
  logic [CORDW-1:0] s1_x, s1_y;
  logic [COLRW-1:0] s1_colr, clr_colr;
  logic [CNTW-1:0]  clr_cnt;

  assign stall     = fb_we && !fb_ready;
  assign adv       = !stall;
  assign oe        = (state == IDLE) && !stall;
  assign accept    = pix_valid && oe;
  assign in_bounds = (32'(x) < 32'(FB_WIDTH)) && (32'(y) < 32'(FB_HEIGHT));
  assign drained   = !s1_valid && (!fb_we || fb_ready);
  // clr_cnt == CNT_END means the last address is already in the output register.
  assign clear_fin = (state == CLEAR) && (clr_cnt == CNT_END) && adv;
  assign busy      = (state != IDLE) || s1_valid || fb_we;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (clear_start) state_n = DRAIN;
      DRAIN:   if (drained)     state_n = CLEAR;
      CLEAR:   if (clear_fin)   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_colr  <= '0;
    end else if (adv) begin
      s1_valid <= accept && in_bounds;
      s1_x     <= x;
      s1_y     <= y;
      s1_colr  <= colr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      clip_cnt <= '0;
    else if (accept && !in_bounds && clip_cnt != 16'hFFFF)
      clip_cnt <= clip_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt  <= '0;
      clr_colr <= '0;
    end else if (state == IDLE && clear_start) begin
      clr_cnt  <= '0;
      clr_colr <= clear_colr;
    end else if (state == CLEAR && adv && clr_cnt != CNT_END) begin
      clr_cnt  <= clr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_we      <= 1'b0;
      fb_colr    <= '0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= clear_fin;
      if (adv) begin
        if (state == CLEAR) begin
          fb_we   <= (clr_cnt != CNT_END);
          fb_colr <= clr_colr;
        end else begin
          fb_we   <= s1_valid;
          fb_colr <= s1_colr;
        end
      end
    end
  end

  assign addr_en = adv && !(state == CLEAR && clr_cnt == CNT_END);

  fb_addr_calc u_addr (
    .clk     (clk),
    .rst     (rst),
    .en      (addr_en),
    .sel_lin (state == CLEAR),
    .lin     (clr_cnt[FB_ADDRW-1:0]),
    .x       (s1_x),
    .y       (s1_y),
    .addr    (fb_addr)
  );
endmodule
